memory_writer: RTL and testbench
================================

Name: memory_writer

Overview:
- Instruction sink for the bytecode translator.
- Accepts a burst of up to six packed 32-bit ARM instruction words plus a word count.
- Writes the words one per clock into an internal word-addressed instruction memory at a running write pointer.
- Exposes a write-strobe mirror and a registered read port for inspection and downstream fetch.

Parameters:
- ADDR_WIDTH, 10, address width of instruction memory.
- DEPTH, 1024, number of 32-bit words in memory (must be 2**ADDR_WIDTH or less).
- MAX_WORDS, 6, maximum words per burst (instructions bus is 32*MAX_WORDS bits).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- write_enable  in  1  burst request, sampled each rising edge
- instructions  in  192  packed words; word k = bits [32k+31:32k]; word 0 is written first
- quantity  in  4  number of words in burst (0..15; clamped)
- busy  out  1  burst in progress; requests ignored
- mem_we  out  1  write strobe for current cycle
- mem_addr  out  ADDR_WIDTH  address being written
- mem_wdata  out  32  word being written
- word_count  out  ADDR_WIDTH+1  total words stored since reset
- full  out  1  word_count == DEPTH
- overflow  out  1  sticky: a word was dropped because memory was full
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  32  registered read data, mem[rd_addr] one cycle later

Behaviour:
- Reset (asynchronous, any time including mid-burst):
  - state=IDLE; busy, mem_we, overflow=0; mem_addr, mem_wdata, word_count, rd_data=0; write pointer=0.
  - Memory contents are not cleared.
  - A burst in progress is abandoned; words already written remain.
- States: IDLE, WRITE.
- IDLE:
  - On an edge with write_enable=1, latch instructions into a shadow register and set remaining = min(quantity, MAX_WORDS) and index k=0.
  - If remaining>0, go to WRITE; if quantity=0, it is a no-op and the state stays IDLE.
  - write_enable=0 keeps IDLE.
- WRITE:
  - busy=1; mem_we=1; mem_addr = write pointer; mem_wdata = shadow word k (all combinational from registered state).
  - At each edge, if not full, mem[ptr] <= word k, ptr++, word_count++; else overflow<=1 and the word is dropped (ptr does not advance).
  - k++, remaining--. When remaining reaches 0, return to IDLE.
- Latency:
  - Request accepted at edge N; word 0 is written at edge N+1; word j at edge N+1+j.
  - busy is high for exactly min(quantity,6) cycles.
- Back-to-back: write_enable while busy=1 (including the last WRITE cycle) is ignored. The earliest next accept is the first edge with busy=0. A source holding write_enable high therefore re-triggers.
- Input changes on instructions/quantity after acceptance do not affect the burst.
- Pointer never wraps: once full, all further words are dropped and overflow is set. full stays 1 until reset.
- Read port: rd_data <= mem[rd_addr] every edge. A same-edge read/write to the same address returns old data.

Optional Feature:
- MEMORY_WRITER_TRACE_EN:
  - When defined, each committed word also prints "%0d %b" (address, word) to the simulation log via $display at the write edge.
  - Dropped words print "DROP %b".
  - When undefined, no trace code is compiled and the logic is identical.

Test Plan:
- Reset then write_enable=1 for 1 cycle, quantity=2, instructions[63:0]={32'hE92D0002,32'hE3A01001} -> mem[0]=E3A01001 at edge N+1, mem[1]=E92D0002 at N+2, busy 2 cycles, word_count=2; rd_addr=1 gives rd_data=E92D0002 next cycle.
- Two bursts: quantity=3 then quantity=1 (second requested while busy, held until busy=0) -> words land at addresses 0..3 contiguously, mid-busy request ignored, word_count=4.
- quantity=0 -> no mem_we, busy stays 0; quantity=9 -> exactly 6 words written, addresses 0..5.
- Fill to DEPTH-1 then burst of 3 -> one word stored at DEPTH-1, full=1, overflow=1, word_count=DEPTH, pointer unchanged.
- Assert reset during 6-word burst after 2 writes -> busy=0 immediately, word_count=0; mem[0..1] retain written values; next burst writes from address 0.
- Change instructions/quantity the cycle after accept -> written words equal the latched values.

Source files
------------

// File: rtl/memory_writer.sv
// Instruction sink: bursts of up to MAX_WORDS packed words written one per clock
// into a word-addressed memory. Optional log trace via MEMORY_WRITER_TRACE_EN.
module memory_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int MAX_WORDS  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic [32*MAX_WORDS-1:0] instructions,
    input  logic [3:0]              quantity,
    output logic                    busy,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [ADDR_WIDTH:0]     word_count,
    output logic                    full,
    output logic                    overflow,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [31:0]             rd_data
);

    localparam logic [3:0]            MAX_Q      = 4'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state;
    logic [32*MAX_WORDS-1:0] shadow;
    logic [3:0]              remaining;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [31:0]             mem [DEPTH];

    assign busy      = (state == WRITE);
    assign mem_we    = busy;
    assign mem_addr  = ptr;
    assign mem_wdata = busy ? shadow[31:0] : '0;
    assign full      = (word_count == FULL_COUNT);

    // The shadow register shifts down one word per write, so word k is always in the low slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            remaining  <= '0;
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_enable) begin
                        shadow    <= instructions;
                        remaining <= (quantity > MAX_Q) ? MAX_Q : quantity;
                        if (quantity != 4'd0)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    shadow    <= shadow >> 32;
                    remaining <= remaining - 4'd1;
                    if (!full) begin
                        word_count <= word_count + 1'b1;
                        // Saturate so the address never wraps back to zero once memory fills.
                        if (ptr != LAST_ADDR)
                            ptr <= ptr + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                    if (remaining == 4'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == WRITE && !full)
            mem[ptr] <= shadow[31:0];
`ifdef MEMORY_WRITER_TRACE_EN
        if (state == WRITE) begin
            if (!full)
                $display("%0d %b", ptr, shadow[31:0]);
            else
                $display("DROP %b", shadow[31:0]);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_memory_writer.sv
// Randomized and directed bench for memory_writer against a queue-based
// transaction model of the burst writer, its memory and its read port.
module tb_memory_writer;

    localparam int AW    = 5;
    localparam int DEPTH = 20;
    localparam int MW    = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            write_enable = 1'b0;
    logic [191:0]    instructions = '0;
    logic [3:0]      quantity = '0;
    logic            busy, mem_we, full, overflow;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [AW:0]     word_count;
    logic [AW-1:0]   rd_addr = '0;
    logic [31:0]     rd_data;

    memory_writer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .instructions(instructions), .quantity(quantity), .busy(busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .full(full), .overflow(overflow),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending words of the accepted burst, memory image, counters.
    logic [31:0] pend[$];
    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    int          count = 0;
    bit          ovf = 1'b0;
    logic [31:0] exp_rd = '0;
    bit          rd_ok = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            count  = 0;
            ovf    = 1'b0;
            exp_rd = '0;
            rd_ok  = 1'b1;
        end else begin
            rd_ok  = known[int'(rd_addr)];
            exp_rd = model_mem[int'(rd_addr)];
            if (pend.size() > 0) begin
                logic [31:0] w;
                w = pend.pop_front();
                if (count < DEPTH) begin
                    model_mem[count] = w;
                    known[count] = 1'b1;
                    count++;
                end else begin
                    ovf = 1'b1;
                end
            end else if (write_enable && quantity != 4'd0) begin
                int n;
                n = (int'(quantity) > MW) ? MW : int'(quantity);
                for (int i = 0; i < n; i++)
                    pend.push_back(instructions[32*i +: 32]);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_eq("busy", 64'(busy), 64'(pend.size() != 0));
            check_eq("mem_we", 64'(mem_we), 64'(pend.size() != 0));
            if (pend.size() != 0 && count < DEPTH) begin
                check_eq("mem_addr", 64'(mem_addr), 64'(count));
                check_eq("mem_wdata", 64'(mem_wdata), 64'(pend[0]));
            end
            check_eq("word_count", 64'(word_count), 64'(count));
            check_eq("full", 64'(full), 64'(count == DEPTH));
            check_eq("overflow", 64'(overflow), 64'(ovf));
            if (rd_ok)
                check_eq("rd_data", 64'(rd_data), 64'(exp_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [191:0] rand_words();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One-cycle request; inputs are scrambled right after acceptance.
    task automatic send(input logic [3:0] q, input logic [191:0] data);
        write_enable = 1'b1;
        quantity     = q;
        instructions = data;
        tick();
        write_enable = 1'b0;
        instructions = rand_words();
        quantity     = 4'($urandom);
    endtask

    task automatic read_check(input string tag, input int a, input logic [31:0] exp);
        rd_addr = AW'(a);
        tick();
        check_eq(tag, 64'(rd_data), 64'(exp));
    endtask

    logic [191:0] a_words, b_words, c_words;

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        checking = 1'b1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_we", 64'(mem_we), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_count", 64'(word_count), 64'd0);
        check_eq("rst_rd", 64'(rd_data), 64'd0);
        reset = 1'b0;

        // Two-word burst
        a_words = rand_words();
        a_words[63:0] = {32'hE92D0002, 32'hE3A01001};
        send(4'd2, a_words);
        idle(3);
        check_eq("t1_count", 64'(word_count), 64'd2);
        read_check("t1_rd0", 0, 32'hE3A01001);
        read_check("t1_rd1", 1, 32'hE92D0002);

        // Request held through a 3-word burst: only re-accepted once busy drops
        do_reset();
        a_words = rand_words();
        b_words = rand_words();
        write_enable = 1'b1;
        quantity = 4'd3;
        instructions = a_words;
        tick();
        quantity = 4'd1;
        instructions = b_words;
        idle(4);
        write_enable = 1'b0;
        idle(3);
        check_eq("t2_count", 64'(word_count), 64'd4);
        read_check("t2_rd2", 2, a_words[95:64]);
        read_check("t2_rd3", 3, b_words[31:0]);

        // Zero-length and clamped bursts
        do_reset();
        send(4'd0, rand_words());
        idle(3);
        check_eq("t3_zero", 64'(word_count), 64'd0);
        c_words = rand_words();
        send(4'd9, c_words);
        idle(8);
        check_eq("t3_clamp", 64'(word_count), 64'd6);
        read_check("t3_rd5", 5, c_words[191:160]);

        // Fill to DEPTH-1, then a 3-word burst overflows
        do_reset();
        repeat (3) begin
            send(4'd6, rand_words());
            idle(6);
        end
        send(4'd1, rand_words());
        idle(1);
        check_eq("t4_pre_full", 64'(full), 64'd0);
        c_words = rand_words();
        send(4'd3, c_words);
        idle(4);
        check_eq("t4_full", 64'(full), 64'd1);
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        check_eq("t4_count", 64'(word_count), 64'(DEPTH));
        read_check("t4_last", DEPTH - 1, c_words[31:0]);

        // Reset in the middle of a 6-word burst
        do_reset();
        c_words = rand_words();
        send(4'd6, c_words);
        idle(2);
        reset = 1'b1;
        #1;
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_count", 64'(word_count), 64'd0);
        tick();
        reset = 1'b0;
        read_check("t5_keep0", 0, c_words[31:0]);
        read_check("t5_keep1", 1, c_words[63:32]);
        a_words = rand_words();
        send(4'd1, a_words);
        idle(2);
        read_check("t5_restart", 0, a_words[31:0]);

        // Randomized traffic, occasional asynchronous reset
        for (int i = 0; i < 800; i++) begin
            write_enable = ($urandom_range(0, 2) == 0);
            quantity     = 4'($urandom);
            instructions = rand_words();
            rd_addr      = AW'($urandom_range(0, DEPTH - 1));
            reset        = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        write_enable = 1'b0;
        idle(10);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
